// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-boundary registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int PIPE_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the core's performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic valid/ready stage register with hold, flush, optional two-entry skid and a
// saturating back-pressure counter.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            occupancy,
  output logic [PIPE_CNT_W-1:0] stall_cycles
);

  logic push;
  logic pop;
  logic stall;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready & ~hold;
  assign stall = in_valid & ~in_ready;

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_t      state;
      logic [WIDTH-1:0] main_q;
      logic [WIDTH-1:0] skid_q;

      // out_data always comes from main_q; skid_q only parks the second entry
      always_ff @(posedge clock) begin
        if (reset) begin
          state  <= EMPTY;
          main_q <= RESET_DATA;
          skid_q <= RESET_DATA;
        end else if (flush) begin
          state <= EMPTY;
        end else if (!hold) begin
          unique case (state)
            EMPTY: begin
              if (push) begin
                main_q <= in_data;
                state  <= HALF;
              end
            end
            HALF: begin
              if (push && pop) begin
                main_q <= in_data;
              end else if (push) begin
                skid_q <= in_data;
                state  <= FULL;
              end else if (pop) begin
                state <= EMPTY;
              end
            end
            FULL: begin
              if (pop) begin
                main_q <= skid_q;
                state  <= HALF;
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end

      assign in_ready  = (state != FULL) & ~hold & ~flush & ~reset;
      assign out_valid = (state != EMPTY);
      assign out_data  = main_q;
      assign occupancy = state;
    end else begin : g_single
      logic             valid_q;
      logic [WIDTH-1:0] main_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_q <= 1'b0;
          main_q  <= RESET_DATA;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (!hold) begin
          if (push) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
          end else if (pop) begin
            valid_q <= 1'b0;
          end
        end
      end

      assign in_ready  = (~valid_q | out_ready) & ~hold & ~flush & ~reset;
      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

  sat_counter #(
    .W(PIPE_CNT_W)
  ) u_stall (
    .clock(clock),
    .inc  (stall),
    .clear(reset),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: SKID=1 and SKID=0 instances share stimulus and are checked
// every cycle against a queue-based reference, plus directed literal checks.
module tb_pipe_stage_buffer;

  localparam logic [31:0] RD1 = 32'hDEAD_BEEF;
  localparam logic [31:0] RD0 = 32'h0000_00C3;

  logic        clock = 1'b0;
  logic        reset, hold, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        ready1, valid1, ready0, valid0;
  logic [31:0] data1, data0, stall1, stall0;
  logic [1:0]  occ1, occ0;

  logic        sc_inc, sc_clear;
  logic [3:0]  sc_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_stage_buffer #(.WIDTH(32), .SKID(1), .RESET_DATA(RD1)) dut (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(ready1), .in_data(in_data),
    .out_valid(valid1), .out_ready(out_ready), .out_data(data1),
    .occupancy(occ1), .stall_cycles(stall1)
  );

  pipe_stage_buffer #(.WIDTH(32), .SKID(0), .RESET_DATA(RD0)) dut0 (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(ready0), .in_data(in_data),
    .out_valid(valid0), .out_ready(out_ready), .out_data(data0),
    .occupancy(occ0), .stall_cycles(stall0)
  );

  sat_counter #(.W(4)) u_sat (
    .clock(clock), .inc(sc_inc), .clear(sc_clear), .count(sc_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference: index 1 is the two-entry buffer, index 0 the single-entry one
  logic [31:0] mq [2][$];
  logic [31:0] m_head [2];
  logic [31:0] m_stall [2];
  bit          model_on = 1'b0;

  function automatic bit model_ready(int id);
    if (reset !== 1'b0 || hold !== 1'b0 || flush !== 1'b0) return 1'b0;
    if (id == 1) return mq[id].size() < 2;
    return (mq[id].size() == 0) || (out_ready === 1'b1);
  endfunction

  always @(negedge clock) begin : compare
    logic        got_ready [2];
    logic        got_valid [2];
    logic [31:0] got_data  [2];
    logic [1:0]  got_occ   [2];
    logic [31:0] got_stall [2];
    bit          rdy, push, pop;
    got_ready[0] = ready0; got_valid[0] = valid0; got_data[0] = data0;
    got_occ[0]   = occ0;   got_stall[0] = stall0;
    got_ready[1] = ready1; got_valid[1] = valid1; got_data[1] = data1;
    got_occ[1]   = occ1;   got_stall[1] = stall1;
    for (int id = 0; id < 2; id++) begin
      rdy = model_ready(id);
      if (model_on) begin
        checkOutput($sformatf("in_ready[skid%0d]", id), 32'(got_ready[id]), 32'(rdy));
        checkOutput($sformatf("out_valid[skid%0d]", id), 32'(got_valid[id]),
                    32'(mq[id].size() > 0));
        checkOutput($sformatf("out_data[skid%0d]", id), got_data[id],
                    (mq[id].size() > 0) ? mq[id][0] : m_head[id]);
        checkOutput($sformatf("occupancy[skid%0d]", id), 32'(got_occ[id]),
                    32'(mq[id].size()));
        checkOutput($sformatf("stall_cycles[skid%0d]", id), got_stall[id], m_stall[id]);
      end
      push = (in_valid === 1'b1) && rdy;
      pop  = (mq[id].size() > 0) && (out_ready === 1'b1) && (hold === 1'b0)
             && (flush === 1'b0);
      if (reset === 1'b1) begin
        mq[id].delete();
        m_head[id]  = (id == 1) ? RD1 : RD0;
        m_stall[id] = 32'd0;
      end else begin
        if (in_valid === 1'b1 && !rdy && m_stall[id] != 32'hFFFF_FFFF) m_stall[id]++;
        if (flush === 1'b1) begin
          mq[id].delete();
        end else begin
          if (pop) void'(mq[id].pop_front());
          if (push) mq[id].push_back(in_data);
        end
      end
      if (mq[id].size() > 0) m_head[id] = mq[id][0];
    end
    if (reset === 1'b1) model_on = 1'b1;
  end

  // Drive one cycle of inputs, then return just after the capturing edge
  task automatic applyStimulus(input logic r, input logic h, input logic f,
                               input logic iv, input logic [31:0] d, input logic ordy);
    reset = r; hold = h; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    sc_inc = 1'b0;
    sc_clear = 1'b1;

    repeat (3) applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                             $urandom, 1'($urandom));
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("reset_valid", 32'(valid1), 32'd0);
    checkOutput("reset_occ", 32'(occ1), 32'd0);
    checkOutput("reset_stall", stall1, 32'd0);
    checkOutput("reset_data_skid1", data1, RD1);
    checkOutput("reset_data_skid0", data0, RD0);
    checkOutput("post_reset_ready", 32'(ready1), 32'd1);

    applyStimulus(0, 0, 0, 1, 32'h11, 1);
    checkOutput("stream_data_11", data1, 32'h11);
    checkOutput("stream_occ_11", 32'(occ1), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h22, 1);
    checkOutput("stream_data_22", data1, 32'h22);
    checkOutput("stream_occ_22", 32'(occ1), 32'd1);
    checkOutput("skid0_replace_data", data0, 32'h22);
    checkOutput("skid0_replace_occ", 32'(occ0), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h33, 1);
    checkOutput("stream_data_33", data1, 32'h33);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("stream_drained", 32'(occ1), 32'd0);

    applyStimulus(0, 0, 0, 1, 32'hA, 0);
    applyStimulus(0, 0, 0, 1, 32'hB, 0);
    checkOutput("bp_occ_full", 32'(occ1), 32'd2);
    checkOutput("bp_ready_low", 32'(ready1), 32'd0);
    checkOutput("bp_stall_before", stall1, 32'd0);
    repeat (4) applyStimulus(0, 0, 0, 1, 32'hC, 0);
    checkOutput("bp_stall_4", stall1, 32'd4);
    checkOutput("bp_head_A", data1, 32'hA);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("bp_pop_then_B", data1, 32'hB);
    checkOutput("bp_occ_1", 32'(occ1), 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("bp_occ_0", 32'(occ1), 32'd0);

    applyStimulus(0, 0, 0, 1, 32'h5, 0);
    repeat (3) applyStimulus(0, 1, 0, 1, 32'h77, 1);
    checkOutput("hold_data", data1, 32'h5);
    checkOutput("hold_occ", 32'(occ1), 32'd1);
    checkOutput("hold_ready", 32'(ready1), 32'd0);
    checkOutput("hold_stall_7", stall1, 32'd7);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    applyStimulus(0, 0, 0, 1, 32'hE1, 0);
    applyStimulus(0, 0, 0, 1, 32'hE2, 0);
    checkOutput("fh_full", 32'(occ1), 32'd2);
    applyStimulus(0, 1, 1, 1, 32'hE3, 1);
    checkOutput("fh_occ", 32'(occ1), 32'd0);
    checkOutput("fh_valid", 32'(valid1), 32'd0);
    checkOutput("fh_data_kept", data1, 32'hE1);
    checkOutput("fh_stall_8", stall1, 32'd8);

    applyStimulus(0, 0, 0, 1, 32'hE4, 0);
    applyStimulus(0, 0, 0, 1, 32'hE5, 0);
    applyStimulus(1, 0, 0, 1, 32'hE6, 1);
    checkOutput("midreset_occ", 32'(occ1), 32'd0);
    checkOutput("midreset_stall", stall1, 32'd0);
    checkOutput("midreset_data", data1, RD1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(63) == 0), 1'($urandom_range(7) == 0),
                    1'($urandom_range(15) == 0), 1'($urandom_range(3) != 0),
                    $urandom, 1'($urandom_range(2) != 0));
    end
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    sc_clear = 1'b1;
    sc_inc = 1'b1;
    @(posedge clock); #1;
    checkOutput("sat_clear", 32'(sc_count), 32'd0);
    sc_clear = 1'b0;
    repeat (14) begin @(posedge clock); #1; end
    checkOutput("sat_at_max_minus_1", 32'(sc_count), 32'hE);
    repeat (3) begin @(posedge clock); #1; end
    checkOutput("sat_saturated", 32'(sc_count), 32'hF);
    sc_inc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
